// File: rtl/wall_tracer_mux_pkg.sv
// Shared definitions for the scanline wall tracer.
// Holds the default fixed-point format, the texture column width and the trace FSM states.
package wall_tracer_mux_pkg;

    localparam int DEF_QM   = 12;
    localparam int DEF_QN   = 12;
    localparam int DEF_W    = DEF_QM + DEF_QN;
    localparam int TEX_BITS = 6;

    typedef enum logic [2:0] {
        StPrepX,
        StPrepY,
        StStep,
        StTest,
        StDone
    } state_e;

endpackage

// File: rtl/wall_tracer_mux_recip.sv
// Combinational fixed-point reciprocal, 1/x in the same QM.QN format as the input.
// Ports:
//   i_val   - signed QM.QN operand
//   i_abs   - 1: return 1/|x| (always positive); 0: keep the sign of x
//   o_recip - result, forced to the largest positive value when 1/|x| does not fit
module wall_tracer_mux_recip #(
    parameter int W  = 24,
    parameter int QN = 12
) (
    input  logic [W-1:0] i_val,
    input  logic         i_abs,
    output logic [W-1:0] o_recip
);

    // 1.0 * 1.0 at 2*QN fractional bits, so the quotient lands on QN fractional bits.
    localparam logic [2*W-1:0] ONE_SQ  = {{(2*W-1){1'b0}}, 1'b1} << (2*QN);
    localparam logic [W-1:0]   MAX_POS = {1'b0, {(W-1){1'b1}}};

    logic           neg;
    logic [W-1:0]   mag;
    logic [W-1:0]   pos;
    logic [2*W-1:0] quot;
    logic           sat;

    assign neg     = i_val[W-1];
    assign mag     = neg ? -i_val : i_val;
    assign quot    = ONE_SQ / {{W{1'b0}}, mag};
    assign sat     = (mag == '0) || (quot > {{W{1'b0}}, MAX_POS});
    assign pos     = sat ? MAX_POS : quot[W-1:0];
    assign o_recip = (neg && !i_abs) ? -pos : pos;

endmodule

// File: rtl/wall_tracer_mux.sv
// Per-scanline DDA wall tracer: one ray per screen row over a 2^MW x 2^MH tile map.
// Ports:
//   clk, reset (async, active high), vsync (frame init), hmax (end of line: publish + next ray)
//   playerX/Y, facingX/Y, vplaneX/Y - signed QM.QN camera state
//   o_map_col/o_map_row, i_map_val   - combinational map ROM lookup
//   o_side, o_hit, o_vdist, o_tex    - result of the last ray, updated with o_valid
//   o_overrun                        - sticky: hmax arrived before a trace finished
module wall_tracer_mux
    import wall_tracer_mux_pkg::*;
#(
    parameter int QM              = 12,
    parameter int QN              = 12,
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int MAX_STEPS       = 64,
    parameter int START_OFFSET    = 272,
    parameter int ADDEND_SHIFT    = 8,
    parameter int VD_INT          = 7,
    parameter int VD_FRAC         = 9
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vsync,
    input  logic                          hmax,
    input  logic [QM+QN-1:0]              playerX,
    input  logic [QM+QN-1:0]              playerY,
    input  logic [QM+QN-1:0]              facingX,
    input  logic [QM+QN-1:0]              facingY,
    input  logic [QM+QN-1:0]              vplaneX,
    input  logic [QM+QN-1:0]              vplaneY,
    output logic [MAP_WIDTH_BITS-1:0]     o_map_col,
    output logic [MAP_HEIGHT_BITS-1:0]    o_map_row,
    input  logic                          i_map_val,
    output logic                          o_side,
    output logic                          o_hit,
    output logic [VD_INT+VD_FRAC-1:0]     o_vdist,
    output logic [5:0]                    o_tex,
    output logic                          o_valid,
    output logic                          o_overrun
);

    localparam int W   = QM + QN;
    localparam int MW  = MAP_WIDTH_BITS;
    localparam int MH  = MAP_HEIGHT_BITS;
    localparam int CW  = $clog2(MAX_STEPS + 1);
    localparam int VDW = VD_INT + VD_FRAC;

    localparam logic [W-1:0] ONE_FX = {{(W-1){1'b0}}, 1'b1} << QN;
    localparam logic [W-1:0] OFFS   = W'(START_OFFSET);

    state_e                state_q, state_d;
    logic signed [W-1:0]   add_x_q, add_x_d, add_y_q, add_y_d;
    logic [W-1:0]          step_x_q, step_x_d, step_y_q, step_y_d;
    logic [W-1:0]          track_x_q, track_x_d, track_y_q, track_y_d;
    logic [MW:0]           map_x_q, map_x_d;
    logic [MH:0]           map_y_q, map_y_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  side_q, side_d, hit_q, hit_d;
    logic                  side_o_q, side_o_d, hit_o_q, hit_o_d;
    logic [VDW-1:0]        vdist_o_q, vdist_o_d;
    logic [TEX_BITS-1:0]   tex_o_q, tex_o_d;
    logic                  valid_q, valid_d, overrun_q, overrun_d;

    logic signed [W-1:0]   dir_x, dir_y, add_init_x, add_init_y;
    logic                  rxi, ryi;
    logic [W-1:0]          frac_x, frac_y, partial_x, partial_y, partial_sel;
    logic [W-1:0]          recip_in, recip_out;
    logic [2*W-1:0]        track_prod;
    logic [W-1:0]          track_init;
    logic [W-1:0]          vdist_raw;
    logic                  vd_over;
    logic [VDW-1:0]        vdist_pub;
    logic signed [W-1:0]   tex_dir;
    logic [W-1:0]          tex_base, tex_sum;
    logic signed [2*W:0]   tex_prod;
    logic [TEX_BITS-1:0]   tex_pub;

    assign dir_x = $signed(facingX) + (add_x_q >>> ADDEND_SHIFT);
    assign dir_y = $signed(facingY) + (add_y_q >>> ADDEND_SHIFT);
    assign rxi   = ~dir_x[W-1] & (|dir_x);
    assign ryi   = ~dir_y[W-1] & (|dir_y);

    assign add_init_x = -($signed(vplaneX) * $signed(OFFS));
    assign add_init_y = -($signed(vplaneY) * $signed(OFFS));

    // Distance from the player to the first grid line along each axis.
    assign frac_x    = {{QM{1'b0}}, playerX[QN-1:0]};
    assign frac_y    = {{QM{1'b0}}, playerY[QN-1:0]};
    assign partial_x = rxi ? ONE_FX - frac_x : frac_x;
    assign partial_y = ryi ? ONE_FX - frac_y : frac_y;

    // One reciprocal and one multiplier serve both axes; PREP_Y selects the Y operands.
    assign recip_in    = (state_q == StPrepY) ? dir_y : dir_x;
    assign partial_sel = (state_q == StPrepY) ? partial_y : partial_x;

    wall_tracer_mux_recip #(
        .W  (W),
        .QN (QN)
    ) u_recip (
        .i_val   (recip_in),
        .i_abs   (1'b1),
        .o_recip (recip_out)
    );

    assign track_prod = recip_out * partial_sel;
    assign track_init = W'(track_prod >> QN);

    // Result formatting: distance to the wall and the texture column along the hit face.
    assign vdist_raw = side_q ? track_y_q - step_y_q : track_x_q - step_x_q;
    assign vd_over   = |(vdist_raw >> (QN + VD_INT));
    assign vdist_pub = (hit_q && !vd_over) ? VDW'(vdist_raw >> (QN - VD_FRAC)) : '1;
    assign tex_dir   = side_q ? dir_x : dir_y;
    assign tex_base  = side_q ? playerX : playerY;
    assign tex_prod  = $signed({1'b0, vdist_raw}) * tex_dir;
    assign tex_sum   = tex_base + W'(tex_prod >>> QN);
    assign tex_pub   = TEX_BITS'(tex_sum >> (QN - TEX_BITS));

    always_comb begin
        state_d   = state_q;
        add_x_d   = add_x_q;
        add_y_d   = add_y_q;
        step_x_d  = step_x_q;
        step_y_d  = step_y_q;
        track_x_d = track_x_q;
        track_y_d = track_y_q;
        map_x_d   = map_x_q;
        map_y_d   = map_y_q;
        cnt_d     = cnt_q;
        side_d    = side_q;
        hit_d     = hit_q;
        side_o_d  = side_o_q;
        hit_o_d   = hit_o_q;
        vdist_o_d = vdist_o_q;
        tex_o_d   = tex_o_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q;

        if (vsync) begin
            state_d   = StPrepX;
            add_x_d   = add_init_x;
            add_y_d   = add_init_y;
            overrun_d = 1'b0;
        end else if (hmax) begin
            valid_d = 1'b1;
            add_x_d = add_x_q + $signed(vplaneX);
            add_y_d = add_y_q + $signed(vplaneY);
            state_d = StPrepX;
            if (state_q == StDone) begin
                side_o_d  = side_q;
                hit_o_d   = hit_q;
                vdist_o_d = vdist_pub;
                tex_o_d   = tex_pub;
            end else begin
                side_o_d  = 1'b0;
                hit_o_d   = 1'b0;
                vdist_o_d = '1;
                tex_o_d   = '0;
                overrun_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StPrepX: begin
                    step_x_d  = recip_out;
                    track_x_d = track_init;
                    state_d   = StPrepY;
                end
                StPrepY: begin
                    step_y_d  = recip_out;
                    track_y_d = track_init;
                    map_x_d   = {1'b0, playerX[QN+MW-1:QN]};
                    map_y_d   = {1'b0, playerY[QN+MH-1:QN]};
                    cnt_d     = '0;
                    state_d   = StStep;
                end
                StStep: begin
                    if (track_x_q < track_y_q) begin
                        map_x_d   = map_x_q + {{MW{~rxi}}, 1'b1};
                        track_x_d = track_x_q + step_x_q;
                        side_d    = 1'b0;
                    end else begin
                        map_y_d   = map_y_q + {{MH{~ryi}}, 1'b1};
                        track_y_d = track_y_q + step_y_q;
                        side_d    = 1'b1;
                    end
                    cnt_d   = cnt_q + CW'(1);
                    state_d = StTest;
                end
                StTest: begin
                    // The extra top bit of the map registers flags a step off either edge.
                    if (i_map_val) begin
                        hit_d   = 1'b1;
                        state_d = StDone;
                    end else if (map_x_q[MW] || map_y_q[MH] || cnt_q == CW'(MAX_STEPS)) begin
                        hit_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        state_d = StStep;
                    end
                end
                StDone:  state_d = StDone;
                default: state_d = StPrepX;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StPrepX;
            add_x_q   <= '0;
            add_y_q   <= '0;
            step_x_q  <= '0;
            step_y_q  <= '0;
            track_x_q <= '0;
            track_y_q <= '0;
            map_x_q   <= '0;
            map_y_q   <= '0;
            cnt_q     <= '0;
            side_q    <= 1'b0;
            hit_q     <= 1'b0;
            side_o_q  <= 1'b0;
            hit_o_q   <= 1'b0;
            vdist_o_q <= '0;
            tex_o_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            add_x_q   <= add_x_d;
            add_y_q   <= add_y_d;
            step_x_q  <= step_x_d;
            step_y_q  <= step_y_d;
            track_x_q <= track_x_d;
            track_y_q <= track_y_d;
            map_x_q   <= map_x_d;
            map_y_q   <= map_y_d;
            cnt_q     <= cnt_d;
            side_q    <= side_d;
            hit_q     <= hit_d;
            side_o_q  <= side_o_d;
            hit_o_q   <= hit_o_d;
            vdist_o_q <= vdist_o_d;
            tex_o_q   <= tex_o_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_map_col = map_x_q[MW-1:0];
    assign o_map_row = map_y_q[MH-1:0];
    assign o_side    = side_o_q;
    assign o_hit     = hit_o_q;
    assign o_vdist   = vdist_o_q;
    assign o_tex     = tex_o_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_wall_tracer_mux.sv
// Directed and randomized checks of wall_tracer_mux against a arithmetic ray-casting model.
module tb_wall_tracer_mux;

    localparam int     W          = 24;
    localparam longint MASK       = 64'hFFFFFF;
    localparam longint MAXP       = 64'h7FFFFF;
    localparam int     TRACE_WAIT = 140;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, vsync, hmax;
    logic [W-1:0] player_x, player_y, facing_x, facing_y, vplane_x, vplane_y;
    bit           wall_map [16][16];

    logic [3:0]  col1, row1, col2, row2;
    logic        mv1, mv2;
    logic        side1, hit1, valid1, ovr1, side2, hit2, valid2, ovr2;
    logic [15:0] vd1, vd2;
    logic [5:0]  tex1, tex2;

    assign mv1 = wall_map[row1][col1];
    assign mv2 = wall_map[row2][col2];

    wall_tracer_mux dut (
        .clk(clk), .reset(reset), .vsync(vsync), .hmax(hmax),
        .playerX(player_x), .playerY(player_y), .facingX(facing_x), .facingY(facing_y),
        .vplaneX(vplane_x), .vplaneY(vplane_y),
        .o_map_col(col1), .o_map_row(row1), .i_map_val(mv1),
        .o_side(side1), .o_hit(hit1), .o_vdist(vd1), .o_tex(tex1),
        .o_valid(valid1), .o_overrun(ovr1)
    );

    wall_tracer_mux #(.MAX_STEPS(4)) dut_short (
        .clk(clk), .reset(reset), .vsync(vsync), .hmax(hmax),
        .playerX(player_x), .playerY(player_y), .facingX(facing_x), .facingY(facing_y),
        .vplaneX(vplane_x), .vplaneY(vplane_y),
        .o_map_col(col2), .o_map_row(row2), .i_map_val(mv2),
        .o_side(side2), .o_hit(hit2), .o_vdist(vd2), .o_tex(tex2),
        .o_valid(valid2), .o_overrun(ovr2)
    );

    int n_cmp = 0;
    int n_bad = 0;
    longint px, py, fx, fy, vx, vy;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sext24(input longint v);
        longint r = v & MASK;
        if (r >= 64'h800000) r = r - (longint'(1) << 24);
        return r;
    endfunction

    function automatic longint recip_ref(input longint d);
        longint m = (d < 0) ? -d : d;
        longint q;
        if (m == 0) return MAXP;
        q = (longint'(1) << 24) / m;
        return (q > MAXP) ? MAXP : q;
    endfunction

    function automatic longint part_ref(input longint p, input longint d);
        longint f = p & 4095;
        return (d > 0) ? 4096 - f : f;
    endfunction

    // Walk grid cells until a wall, a map edge or the step budget; then format the result.
    function automatic void model(input longint mpx, input longint mpy, input longint dx,
                                  input longint dy, input int max_steps, output bit hit,
                                  output bit side, output logic [15:0] vd16,
                                  output logic [5:0] tex);
        longint sx, sy, tx, ty, mx, my, vd, t;
        int     n;
        bit     done;
        sx = recip_ref(dx);
        sy = recip_ref(dy);
        tx = ((sx * part_ref(mpx, dx)) >> 12) & MASK;
        ty = ((sy * part_ref(mpy, dy)) >> 12) & MASK;
        mx = (mpx >> 12) & 15;
        my = (mpy >> 12) & 15;
        n = 0; done = 0; hit = 0; side = 0;
        while (!done) begin
            if (tx < ty) begin
                mx = mx + ((dx > 0) ? 1 : -1);
                tx = (tx + sx) & MASK;
                side = 0;
            end else begin
                my = my + ((dy > 0) ? 1 : -1);
                ty = (ty + sy) & MASK;
                side = 1;
            end
            n++;
            if (wall_map[int'(my & 15)][int'(mx & 15)]) begin
                hit = 1; done = 1;
            end else if (mx < 0 || mx > 15 || my < 0 || my > 15) begin
                done = 1;
            end else if (n == max_steps) begin
                done = 1;
            end
        end
        vd = (side ? ty - sy : tx - sx) & MASK;
        vd16 = (!hit || (vd >> 19) != 0) ? 16'hFFFF : 16'((vd >> 3) & 64'hFFFF);
        t = (side ? mpx : mpy) + ((vd * (side ? dx : dy)) >>> 12);
        tex = 6'((t >> 6) & 63);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start();
        vsync = 1'b1;
        tick();
        tick();
        vsync = 1'b0;
    endtask

    task automatic pulse_hmax();
        hmax = 1'b1;
        tick();
        hmax = 1'b0;
    endtask

    task automatic set_inputs(input longint a, input longint b, input longint c,
                              input longint d, input longint e, input longint f);
        px = a; py = b; fx = c; fy = d; vx = e; vy = f;
        player_x = W'(a); player_y = W'(b); facing_x = W'(c);
        facing_y = W'(d); vplane_x = W'(e); vplane_y = W'(f);
    endtask

    task automatic clear_map();
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) wall_map[y][x] = 1'b0;
    endtask

    // Publish the current ray with hmax and compare against the model for addends rax/ray.
    task automatic run_ray(input string tag, input longint rax, input longint ray,
                           input logic exp_ovr);
        longint      dx, dy;
        bit          h, s;
        logic [15:0] vd;
        logic [5:0]  tx;
        dx = sext24(fx + (rax >>> 8));
        dy = sext24(fy + (ray >>> 8));
        model(px, py, dx, dy, 64, h, s, vd, tx);
        pulse_hmax();
        check({tag, "_valid"}, valid1, 1);
        check({tag, "_hit"}, hit1, h);
        check({tag, "_side"}, side1, s);
        check({tag, "_vdist"}, vd1, vd);
        if (h) check({tag, "_tex"}, tex1, tx);
        check({tag, "_ovr"}, ovr1, exp_ovr);
    endtask

    initial begin
        longint ray0, ray1, rax, ray;
        int     pulses;
        reset = 1'b1; vsync = 1'b0; hmax = 1'b0;
        clear_map();
        set_inputs(0, 0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_valid", valid1, 0);
        check("rst_hit", hit1, 0);
        check("rst_vdist", vd1, 0);
        check("rst_tex", tex1, 0);
        check("rst_ovr", ovr1, 0);
        check("rst_col", col1, 0);
        reset = 1'b0;

        // Wall column at x = 3, looking along +X from (1.5, 1.5).
        clear_map();
        for (int y = 0; y < 16; y++) wall_map[y][3] = 1'b1;
        set_inputs(64'h1800, 64'h1800, 64'h1000, 0, 0, 0);
        frame_start(); repeat (40) tick(); pulse_hmax();
        check("a_valid", valid1, 1);
        check("a_hit", hit1, 1);
        check("a_side", side1, 0);
        check("a_vdist", vd1, 32'h300);
        check("a_tex", tex1, 32);
        check("a_ovr", ovr1, 0);
        tick();
        check("a_valid_drop", valid1, 0);

        // Wall row at y = 4, looking along +Y from (2.25, 1.25).
        clear_map();
        for (int x = 0; x < 16; x++) wall_map[4][x] = 1'b1;
        set_inputs(64'h2400, 64'h1400, 0, 64'h1000, 0, 0);
        frame_start(); repeat (40) tick(); pulse_hmax();
        check("b_hit", hit1, 1);
        check("b_side", side1, 1);
        check("b_vdist", vd1, 32'h580);
        check("b_tex", tex1, 16);

        // Empty map: ray leaves through the right edge.
        clear_map();
        set_inputs(64'h8800, 64'h8800, 64'h1000, 0, 0, 0);
        frame_start(); repeat (40) tick(); pulse_hmax();
        check("c_valid", valid1, 1);
        check("c_hit", hit1, 0);
        check("c_vdist", vd1, 32'hFFFF);
        check("c_ovr", ovr1, 0);

        // Wall at x = 14: the 4-step instance gives up, the default one reaches it.
        for (int y = 0; y < 16; y++) wall_map[y][14] = 1'b1;
        set_inputs(64'h1800, 64'h1800, 64'h1000, 0, 0, 0);
        frame_start(); repeat (40) tick(); pulse_hmax();
        check("d_short_valid", valid2, 1);
        check("d_short_hit", hit2, 0);
        check("d_short_vdist", vd2, 32'hFFFF);
        check("d_long_hit", hit1, 1);
        check("d_long_vdist", vd1, 32'h1900);
        check("d_long_tex", tex1, 32);

        // Overrun: hmax while the first ray is still stepping.
        clear_map();
        for (int y = 0; y < 16; y++) wall_map[y][3] = 1'b1;
        set_inputs(64'h1800, 64'h1800, 64'h1000, 64'h4400, 0, 64'h4000);
        ray0 = sext24(-vy * 272);
        ray1 = sext24(ray0 + vy);
        frame_start(); tick(); tick(); pulse_hmax();
        check("ovr_valid", valid1, 1);
        check("ovr_hit", hit1, 0);
        check("ovr_vdist", vd1, 32'hFFFF);
        check("ovr_side", side1, 0);
        check("ovr_tex", tex1, 0);
        check("ovr_flag", ovr1, 1);
        repeat (TRACE_WAIT) tick();
        run_ray("ovr_row1", 0, ray1, 1'b1);

        // Second vsync mid-trace restarts the frame without a result pulse.
        repeat (5) tick();
        vsync = 1'b1; tick();
        check("vs_ovr_clr", ovr1, 0);
        check("vs_valid", valid1, 0);
        tick(); vsync = 1'b0;
        pulses = 0;
        for (int i = 0; i < TRACE_WAIT; i++) begin
            tick();
            if (valid1) pulses++;
        end
        check("vs_no_valid", pulses, 0);
        run_ray("vs_row0", 0, ray0, 1'b0);

        // Reset in the middle of a trace clears every output at once.
        repeat (5) tick();
        reset = 1'b1; #1;
        check("mrst_hit", hit1, 0);
        check("mrst_vdist", vd1, 0);
        check("mrst_tex", tex1, 0);
        check("mrst_valid", valid1, 0);
        check("mrst_ovr", ovr1, 0);
        tick(); tick(); reset = 1'b0;
        set_inputs(64'h1800, 64'h1800, 64'h1000, 0, 0, 0);
        frame_start(); repeat (40) tick(); pulse_hmax();
        check("mrst_post_valid", valid1, 1);
        check("mrst_post_hit", hit1, 1);
        check("mrst_post_vdist", vd1, 32'h300);

        // Random maps, players and cameras; four rows per frame.
        for (int f = 0; f < 8; f++) begin
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++) wall_map[y][x] = ($urandom_range(0, 99) < 20);
            set_inputs(longint'($urandom_range(4096, 15 * 4096 - 1)),
                       longint'($urandom_range(4096, 15 * 4096 - 1)),
                       longint'($urandom_range(0, 8192)) - 4096,
                       longint'($urandom_range(0, 8192)) - 4096,
                       longint'($urandom_range(0, 4096)) - 2048,
                       longint'($urandom_range(0, 4096)) - 2048);
            rax = sext24(-vx * 272);
            ray = sext24(-vy * 272);
            frame_start();
            for (int r = 0; r < 4; r++) begin
                repeat (TRACE_WAIT) tick();
                run_ray($sformatf("rnd_f%0d_r%0d", f, r), rax, ray, 1'b0);
                rax = sext24(rax + vx);
                ray = sext24(ray + vy);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wall_tracer_mux.md
Name: wall_tracer_mux

Overview:
- Next-generation per-scanline DDA ray tracer: one ray per screen row, stepping a 2^MW x 2^MH tile map and presenting side, distance and texture column on each `hmax`.
- Adds four things: full parametrisation, one time-shared reciprocal instead of two, bounded tracing (step limit, off-map exit), and explicit result-valid and overrun reporting.
- Sits between the vsync/hmax timing generator and the row renderer; reads the map ROM combinationally.

Parameters:
- QM, 12, integer bits of signed fixed-point (W = QM+QN)
- QN, 12, fractional bits
- MAP_WIDTH_BITS, 4, map column address bits (MW)
- MAP_HEIGHT_BITS, 4, map row address bits (MH)
- MAX_STEPS, 64, DDA steps per ray before forced miss
- START_OFFSET, 272, rayAddend starts at -vplane*START_OFFSET each frame
- ADDEND_SHIFT, 8, rayDir = facing + (rayAddend >>> ADDEND_SHIFT)
- VD_INT, 7, integer bits of o_vdist
- VD_FRAC, 9, fractional bits of o_vdist

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  high: hold FSM in frame-init
- hmax  in  1  end-of-line strobe: publish result, start next ray
- playerX, playerY, facingX, facingY, vplaneX, vplaneY  in  W each  signed QM.QN
- o_map_col  out  MW  map column under test
- o_map_row  out  MH  map row under test
- i_map_val  in  1  nonzero = wall at (o_map_col, o_map_row), same cycle
- o_side  out  1  0 = X-side hit, 1 = Y-side hit
- o_hit  out  1  1 = wall found; 0 = miss/timeout/overrun
- o_vdist  out  VD_INT+VD_FRAC  unsigned visual wall distance
- o_tex  out  6  texture column 0..63
- o_valid  out  1  one-cycle pulse when outputs update
- o_overrun  out  1  sticky: hmax arrived before trace finished; cleared by vsync

Behaviour:
- Reset (async):
  - all outputs 0.
  - state = PREP_X; rayAddend = 0; mapX/mapY, trackDist, step counter = 0.
- vsync high (priority over everything else):
  - state = PREP_X; rayAddend = -vplane*START_OFFSET (per axis).
  - o_overrun cleared; other outputs hold; no o_valid.
- rayDir = facing + (rayAddend >>> ADDEND_SHIFT).
- Direction flags: rxi = rayDirX > 0, ryi = rayDirY > 0.
- States:
  - PREP_X: the shared reciprocal is fed |rayDirX|; latch stepDistX; trackDistX = stepDistX*partialX (middle W bits of the product). Then PREP_Y.
  - PREP_Y: same for the Y axis; also latch mapX/mapY = integer part of the player position; step counter = 0. Then STEP.
  - STEP: if trackDistX < trackDistY (unsigned compare), step X: map ±1 per rxi, trackDistX += stepDistX, side = 0. Otherwise step Y likewise, side = 1. Counter +1. Then TEST.
  - TEST:
    - i_map_val != 0 -> DONE, hit = 1.
    - else if the map coordinate left [0, 2^MW-1] / [0, 2^MH-1] (the stored map regs are MW+1 / MH+1 bits wide) -> DONE, hit = 0.
    - else if counter == MAX_STEPS -> DONE, hit = 0.
    - else -> STEP.
  - DONE: wait for hmax.
- Partial step:
  - partial = 1 - frac(player) when the direction is positive, else frac(player).
  - frac = 0 with a positive direction gives partial = 1.0.
- Reciprocal saturation: stepDist forced to the all-ones positive maximum. trackDist is unsigned and wraps at most once.
- Distance: vdist = trackDist(side) - stepDist(side).
  - Output bits [VD_INT-1 : -VD_FRAC].
  - If any higher integer bit is set, or hit = 0, o_vdist = all ones.
- Texture: o_tex = bits [-1:-6] of (side ? playerX + vdist*rayDirX : playerY + vdist*rayDirY). One multiplier is shared, operand selected by side.
- hmax in DONE:
  - next cycle: o_side, o_hit, o_vdist, o_tex registered; o_valid = 1 for one cycle.
  - rayAddend += vplane; state = PREP_X.
- hmax in any other state (overrun):
  - publish o_hit = 0, o_vdist = all ones, o_side = 0, o_tex = 0; o_valid pulse; o_overrun = 1.
  - rayAddend += vplane; abort to PREP_X.
- Minimum trace latency: PREP_X + PREP_Y + 2 cycles per DDA step.

Decomposition:
- Shared package/include (extend fixed_point_params): W, QM/QN field macros, F/UF/F2 widths, state encodings (PREP_X, PREP_Y, STEP, TEST, DONE), TEX_BITS = 6.
- Sub-module: the existing reciprocal, instantiated once (i_abs = 1) with a state-selected input mux.

Test Plan:
- Reset asserted mid-trace -> all outputs 0 immediately; after release plus vsync pulse, first result is valid.
- Player (1.5,1.5), facing (1,0), vplane 0, wall column x=3, hmax after 40 cycles -> o_valid pulse, hit = 1, side = 0, o_vdist = 0x300 (1.5), o_tex = 32.
- Player (2.25,1.25), facing (0,1), vplane 0, wall row y=4 -> hit = 1, side = 1, o_vdist = 0x580 (2.75), o_tex = 16.
- Empty 16x16 map, player (8.5,8.5), facing (1,0) -> exit at mapX = 16, hit = 0, o_vdist = 0xFFFF, o_overrun = 0.
- MAX_STEPS = 4, wall at x=14, player (1.5,1.5), facing (1,0) -> hit = 0 after 4 steps, o_vdist = 0xFFFF.
- hmax 2 cycles after vsync falls -> o_valid, hit = 0, o_overrun = 1 until next vsync, rayAddend advanced. A second vsync mid-trace -> restart, no o_valid.
